// File: rtl/enc_cola_4a2.sv
// enc_cola_4a2: sequential priority encoder, one index per VALID/READY handshake.
// Define ENC_COLA_MSB_FIRST_EN to emit the highest set index first.
module enc_cola_4a2 #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] D,
    input  logic         LOAD,
    output logic [W-1:0] A,
    output logic         VALID,
    input  logic         READY,
    output logic         BUSY,
    output logic         DONE
);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t       r_state;
    state_t       w_state_n;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_n;
    logic [N-1:0] w_rem;
    logic [W-1:0] r_a;
    logic [W-1:0] w_a_n;
    logic         r_valid;
    logic         w_valid_n;
    logic         r_busy;
    logic         w_busy_n;
    logic         r_done;
    logic         w_done_n;

    // Priority pick of the next index to emit from a request vector.
    function automatic logic [W-1:0] f_enc(input logic [N-1:0] v);
        logic [W-1:0] idx;
        idx = '0;
`ifdef ENC_COLA_MSB_FIRST_EN
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = W'(i);
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) idx = W'(i);
        end
`endif
        return idx;
    endfunction

    // Pending bits left once the current index is accepted.
    always_comb begin
        w_rem = r_pend & ~(N'(1) << r_a);
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_n = r_state;
        w_pend_n  = r_pend;
        w_a_n     = r_a;
        w_valid_n = r_valid;
        w_busy_n  = r_busy;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (LOAD) begin
                    if (D != '0) begin
                        w_pend_n  = D;
                        w_a_n     = f_enc(D);
                        w_valid_n = 1'b1;
                        w_busy_n  = 1'b1;
                        w_state_n = S_SCAN;
                    end else begin
                        w_done_n = 1'b1;
                    end
                end
            end
            S_SCAN: begin
                if (READY) begin
                    w_pend_n = w_rem;
                    if (w_rem != '0) begin
                        w_a_n = f_enc(w_rem);
                    end else begin
                        w_valid_n = 1'b0;
                        w_busy_n  = 1'b0;
                        w_done_n  = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any batch in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_a     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pend  <= w_pend_n;
            r_a     <= w_a_n;
            r_valid <= w_valid_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign A     = r_a;
    assign VALID = r_valid;
    assign BUSY  = r_busy;
    assign DONE  = r_done;

endmodule

// File: tb/tb_enc_cola_4a2.sv
// Testbench for enc_cola_4a2: directed table, reset corner, random vs model.
module tb_enc_cola_4a2;

    logic       CLK;
    logic       RST_N;
    logic [3:0] D;
    logic       LOAD;
    logic [1:0] A;
    logic       VALID;
    logic       READY;
    logic       BUSY;
    logic       DONE;

    int total;
    int bad;

    // Reference model: queue of indices still to be emitted.
    int q[$];
    bit m_done;

    typedef struct {
        bit       load;
        bit [3:0] d;
        bit       ready;
        bit       ev;
        int       ea;
        bit       eb;
        bit       ed;
        string    nm;
    } vec_t;

    vec_t tbl[$];

    enc_cola_4a2 dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (D),
        .LOAD  (LOAD),
        .A     (A),
        .VALID (VALID),
        .READY (READY),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int pick(int lsb, int msb);
`ifdef ENC_COLA_MSB_FIRST_EN
        return msb;
`else
        return lsb;
`endif
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(bit l, bit [3:0] d, bit r);
        if (q.size() == 0) begin
            m_done = l && (d == 0);
            if (l && d != 0) begin
`ifdef ENC_COLA_MSB_FIRST_EN
                for (int i = 3; i >= 0; i--) if (d[i]) q.push_back(i);
`else
                for (int i = 0; i < 4; i++) if (d[i]) q.push_back(i);
`endif
            end
        end else begin
            m_done = 1'b0;
            if (r) begin
                void'(q.pop_front());
                if (q.size() == 0) m_done = 1'b1;
            end
        end
    endtask

    task automatic step(bit l, bit [3:0] d, bit r);
        LOAD  = l;
        D     = d;
        READY = r;
        @(posedge CLK);
        model_edge(l, d, r);
        #1;
    endtask

    task automatic chk_model(string nm);
        bit mv;
        mv = (q.size() != 0);
        chk({nm, ".valid"}, int'(VALID), int'(mv));
        chk({nm, ".busy"}, int'(BUSY), int'(mv));
        chk({nm, ".done"}, int'(DONE), int'(m_done));
        if (mv) chk({nm, ".a"}, int'(A), q[0]);
    endtask

    task automatic add(bit l, bit [3:0] d, bit r, bit ev, int ea, bit eb, bit ed, string nm);
        vec_t v;
        v = '{l, d, r, ev, ea, eb, ed, nm};
        tbl.push_back(v);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        m_done = 1'b0;
        RST_N  = 1'b0;
        LOAD   = 1'b0;
        D      = 4'b0;
        READY  = 1'b0;

        // Single hot bit, then DONE.
        add(1, 4'b0100, 1, 1, 2, 1, 0, "oh_first");
        add(0, 4'b0000, 1, 0, 0, 0, 1, "oh_done");
        add(0, 4'b0000, 1, 0, 0, 0, 0, "oh_idle");
        // Multi-hot back-to-back.
        add(1, 4'b1011, 1, 1, pick(0, 3), 1, 0, "mh_0");
        add(0, 4'b0000, 1, 1, pick(1, 1), 1, 0, "mh_1");
        add(0, 4'b0000, 1, 1, pick(3, 0), 1, 0, "mh_2");
        add(0, 4'b0000, 1, 0, 0, 0, 1, "mh_done");
        // Backpressure: A held for 5 cycles.
        add(1, 4'b0110, 0, 1, pick(1, 2), 1, 0, "bp_0");
        for (int i = 0; i < 4; i++)
            add(0, 4'b0000, 0, 1, pick(1, 2), 1, 0, "bp_hold");
        add(0, 4'b0000, 1, 1, pick(2, 1), 1, 0, "bp_next");
        add(0, 4'b0000, 1, 0, 0, 0, 1, "bp_done");
        // LOAD during SCAN is ignored.
        add(1, 4'b0011, 0, 1, pick(0, 1), 1, 0, "ig_0");
        add(1, 4'b1000, 1, 1, pick(1, 0), 1, 0, "ig_1");
        add(0, 4'b0000, 1, 0, 0, 0, 1, "ig_done");
        add(0, 4'b0000, 1, 0, 0, 0, 0, "ig_quiet");
        // Empty batch.
        add(1, 4'b0000, 0, 0, 0, 0, 1, "empty_done");
        add(0, 4'b0000, 0, 0, 0, 0, 0, "empty_after");

        repeat (2) @(posedge CLK);
        #1;
        chk("rst.valid", int'(VALID), 0);
        chk("rst.busy", int'(BUSY), 0);
        chk("rst.done", int'(DONE), 0);
        chk("rst.a", int'(A), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].load, tbl[i].d, tbl[i].ready);
            chk({tbl[i].nm, ".valid"}, int'(VALID), int'(tbl[i].ev));
            chk({tbl[i].nm, ".busy"}, int'(BUSY), int'(tbl[i].eb));
            chk({tbl[i].nm, ".done"}, int'(DONE), int'(tbl[i].ed));
            if (tbl[i].ev) chk({tbl[i].nm, ".a"}, int'(A), tbl[i].ea);
            chk({tbl[i].nm, ".nodual"}, int'(VALID && DONE), 0);
        end

        // Async reset mid-batch.
        step(1, 4'b1111, 1);
        chk("ar.a0", int'(A), pick(0, 3));
        step(0, 4'b0000, 1);
        chk("ar.a1", int'(A), pick(1, 2));
        #3;
        RST_N = 1'b0;
        #1;
        chk("ar.a", int'(A), 0);
        chk("ar.valid", int'(VALID), 0);
        chk("ar.busy", int'(BUSY), 0);
        chk("ar.done", int'(DONE), 0);
        q.delete();
        m_done = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        step(0, 4'b0000, 1);
        chk("ar.post_done", int'(DONE), 0);
        chk("ar.post_valid", int'(VALID), 0);
        step(1, 4'b0001, 1);
        chk("ar.idle_load_v", int'(VALID), 1);
        chk("ar.idle_load_a", int'(A), 0);
        step(0, 4'b0000, 1);
        chk("ar.idle_done", int'(DONE), 1);

        // Random traffic against the model.
        q.delete();
        m_done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 3) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 2) != 0));
            chk_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
